// File: rtl/decoder3x8_seq.sv
// decoder3x8_seq: 3-to-8 one-hot decoder behind a 4-entry code FIFO.
// Each decoded word is held for HOLD cycles, then followed by GAP idle cycles.
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   flush     - synchronous clear of FIFO and current output word
//   in_valid  - in_code is presented
//   in_code   - binary code 0..7
//   in_ready  - a code can be accepted this cycle
//   y         - registered one-hot word (8'h00 when not driving)
//   y_valid   - y holds a decoded word
//   level     - number of queued codes, 0..4
module decoder3x8_seq #(
    parameter int HOLD = 4,
    parameter int GAP  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       in_valid,
    input  logic [2:0] in_code,
    output logic       in_ready,
    output logic [7:0] y,
    output logic       y_valid,
    output logic [2:0] level
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic [7:0] HOLD_LD = 8'(HOLD - 1);
    // With GAP=0 the GAP state is never entered; the load value is unused.
    localparam logic [7:0] GAP_LD  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
    localparam bit         HAS_GAP = (GAP != 0);

    logic [2:0] r_mem [4];
    logic [1:0] r_wp;
    logic [1:0] r_rp;
    logic [2:0] r_level;
    logic [1:0] r_state;
    logic [7:0] r_cnt;
    logic [7:0] r_y;
    logic       r_yv;

    logic       w_push;
    logic       w_pop;
    logic       w_has;
    logic       w_done;
    logic [7:0] w_onehot;
    logic [1:0] w_state_nx;
    logic [7:0] w_cnt_nx;
    logic [7:0] w_y_nx;
    logic       w_yv_nx;

    // Readiness looks only at the registered level, so a pop in the
    // same cycle never opens a slot in a full FIFO.
    assign in_ready = rst_n && (r_level < 3'd4) && !flush;
    assign w_push   = in_valid && in_ready;
    assign w_has    = (r_level != 3'd0);
    assign w_done   = (r_cnt == 8'd0);
    assign w_onehot = 8'd1 << r_mem[r_rp];

    assign y       = r_y;
    assign y_valid = r_yv;
    assign level   = r_level;

    always_comb begin
        w_pop      = 1'b0;
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_y_nx     = r_y;
        w_yv_nx    = r_yv;
        case (r_state)
            S_IDLE: begin
                if (w_has) begin
                    w_pop      = 1'b1;
                    w_y_nx     = w_onehot;
                    w_yv_nx    = 1'b1;
                    w_cnt_nx   = HOLD_LD;
                    w_state_nx = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (!w_done) begin
                    w_cnt_nx = r_cnt - 8'd1;
                end else if (HAS_GAP) begin
                    w_y_nx     = 8'h00;
                    w_yv_nx    = 1'b0;
                    w_cnt_nx   = GAP_LD;
                    w_state_nx = S_GAP;
                end else if (w_has) begin
                    // Back-to-back: next word replaces the current one.
                    w_pop      = 1'b1;
                    w_y_nx     = w_onehot;
                    w_yv_nx    = 1'b1;
                    w_cnt_nx   = HOLD_LD;
                end else begin
                    w_y_nx     = 8'h00;
                    w_yv_nx    = 1'b0;
                    w_state_nx = S_IDLE;
                end
            end
            S_GAP: begin
                if (!w_done) begin
                    w_cnt_nx = r_cnt - 8'd1;
                end else if (w_has) begin
                    w_pop      = 1'b1;
                    w_y_nx     = w_onehot;
                    w_yv_nx    = 1'b1;
                    w_cnt_nx   = HOLD_LD;
                    w_state_nx = S_DRIVE;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_y_nx     = 8'h00;
                w_yv_nx    = 1'b0;
                w_cnt_nx   = 8'd0;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_mem[i] <= 3'd0;
            r_wp    <= 2'd0;
            r_rp    <= 2'd0;
            r_level <= 3'd0;
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_y     <= 8'h00;
            r_yv    <= 1'b0;
        end else if (flush) begin
            r_wp    <= 2'd0;
            r_rp    <= 2'd0;
            r_level <= 3'd0;
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_y     <= 8'h00;
            r_yv    <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= in_code;
                r_wp        <= r_wp + 2'd1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 2'd1;
            end
            r_level <= r_level + {2'b00, w_push} - {2'b00, w_pop};
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_y     <= w_y_nx;
            r_yv    <= w_yv_nx;
        end
    end

endmodule

// File: tb/tb_decoder3x8_seq.sv
// tb_decoder3x8_seq: scoreboard bench for decoder3x8_seq.
// u0 runs HOLD=4/GAP=1, u1 runs HOLD=2/GAP=0.
`timescale 1ns/1ps
module tb_decoder3x8_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush0, iv0, flush1, iv1;
    logic [2:0] ic0, ic1;
    logic       ir0, yv0, ir1, yv1;
    logic [7:0] y0, y1;
    logic [2:0] lv0, lv1;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int ab_req0  = 0;
    int ab_seen0 = 0;

    always #5 clk = ~clk;

    decoder3x8_seq #(.HOLD(4), .GAP(1)) u0 (
        .clk(clk), .rst_n(rst_n), .flush(flush0),
        .in_valid(iv0), .in_code(ic0), .in_ready(ir0),
        .y(y0), .y_valid(yv0), .level(lv0)
    );

    decoder3x8_seq #(.HOLD(2), .GAP(0)) u1 (
        .clk(clk), .rst_n(rst_n), .flush(flush1),
        .in_valid(iv1), .in_code(ic1), .in_ready(ir1),
        .y(y1), .y_valid(yv1), .level(lv1)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitor u0: pops an expected word at each word start, then checks
    // the word stays stable for HOLD cycles and is preceded by a gap.
    bit         pv0 = 1'b0;
    int         run0 = 0;
    logic [7:0] cur0 = 8'h00;
    always @(negedge clk) begin
        if (yv0) begin
            if (!pv0 || run0 == 4) begin
                chk("u0_gap_before_word", {31'd0, pv0}, 0);
                if (q0.size() == 0) begin
                    chk("u0_unexpected_word", {24'd0, y0}, 0);
                    cur0 = y0;
                end else begin
                    cur0 = q0.pop_front();
                    chk("u0_word", {24'd0, y0}, {24'd0, cur0});
                end
                run0 = 1;
            end else begin
                chk("u0_hold_stable", {24'd0, y0}, {24'd0, cur0});
                run0++;
            end
        end else begin
            chk("u0_idle_zero", {24'd0, y0}, 0);
            if (pv0) begin
                if (ab_seen0 != ab_req0) ab_seen0 = ab_req0;
                else chk("u0_hold_len", run0, 4);
            end
            run0 = 0;
        end
        pv0 = yv0;
    end

    bit         pv1 = 1'b0;
    int         run1 = 0;
    logic [7:0] cur1 = 8'h00;
    always @(negedge clk) begin
        if (yv1) begin
            if (!pv1 || run1 == 2) begin
                if (q1.size() == 0) begin
                    chk("u1_unexpected_word", {24'd0, y1}, 0);
                    cur1 = y1;
                end else begin
                    cur1 = q1.pop_front();
                    chk("u1_word", {24'd0, y1}, {24'd0, cur1});
                end
                run1 = 1;
            end else begin
                chk("u1_hold_stable", {24'd0, y1}, {24'd0, cur1});
                run1++;
            end
        end else begin
            chk("u1_idle_zero", {24'd0, y1}, 0);
            if (pv1) chk("u1_hold_len", run1, 2);
            run1 = 0;
        end
        pv1 = yv1;
    end

    // Offer a code to u0 until accepted; records the expected word.
    task automatic push0(input logic [2:0] c);
        bit done = 1'b0;
        iv0 = 1'b1;
        ic0 = c;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (ir0) begin
                @(posedge clk);
                q0.push_back(8'd1 << c);
                done = 1'b1;
                #1;
            end else begin
                chk("u0_full_level", {29'd0, lv0}, 4);
                @(posedge clk);
                #1;
            end
        end
        iv0 = 1'b0;
        if (!done) chk("u0_push_timeout", 0, 1);
    endtask

    task automatic wait_idle0(input int maxc);
        bit ok = 1'b0;
        for (int k = 0; k < maxc && !ok; k++) begin
            @(posedge clk);
            #1;
            if (q0.size() == 0 && !yv0 && lv0 == 3'd0) ok = 1'b1;
        end
        chk("u0_drain", {31'd0, ok}, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        flush0 = 1'b0;
        flush1 = 1'b0;
        iv0    = 1'b0;
        iv1    = 1'b0;
        ic0    = 3'd0;
        ic1    = 3'd0;

        #2;
        chk("rst_y", {24'd0, y0}, 0);
        chk("rst_y_valid", {31'd0, yv0}, 0);
        chk("rst_level", {29'd0, lv0}, 0);
        chk("rst_in_ready", {31'd0, ir0}, 0);

        #20;
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", {31'd0, ir0}, 1);
        chk("release_level", {29'd0, lv0}, 0);
        @(posedge clk);
        #1;

        // Single code 5: latency and hold/gap timing.
        iv0 = 1'b1;
        ic0 = 3'd5;
        @(negedge clk);
        chk("c5_ready", {31'd0, ir0}, 1);
        @(posedge clk);
        q0.push_back(8'h20);
        #1;
        iv0 = 1'b0;
        chk("c5_level_one", {29'd0, lv0}, 1);
        chk("c5_not_yet_valid", {31'd0, yv0}, 0);
        @(posedge clk);
        #1;
        chk("c5_y_first", {24'd0, y0}, 32'h20);
        chk("c5_valid_first", {31'd0, yv0}, 1);
        chk("c5_level_zero", {29'd0, lv0}, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("c5_y_last", {24'd0, y0}, 32'h20);
        @(posedge clk);
        #1;
        chk("c5_gap_y", {24'd0, y0}, 0);
        chk("c5_gap_valid", {31'd0, yv0}, 0);
        @(posedge clk);
        #1;
        chk("c5_idle_y", {24'd0, y0}, 0);
        chk("c5_idle_level", {29'd0, lv0}, 0);
        wait_idle0(50);

        // Codes 0..7 streamed: fills FIFO, wraps pointers.
        for (int i = 0; i < 8; i++) push0(3'(i));
        wait_idle0(200);

        // Flush mid-DRIVE with three codes queued and a code offered.
        push0(3'd1);
        push0(3'd2);
        push0(3'd3);
        push0(3'd4);
        chk("fl_level_before", {29'd0, lv0}, 3);
        chk("fl_driving", {24'd0, y0}, 32'h02);
        flush0 = 1'b1;
        iv0    = 1'b1;
        ic0    = 3'd7;
        ab_req0++;
        q0.delete();
        @(negedge clk);
        chk("fl_in_ready", {31'd0, ir0}, 0);
        @(posedge clk);
        #1;
        flush0 = 1'b0;
        iv0    = 1'b0;
        chk("fl_y", {24'd0, y0}, 0);
        chk("fl_valid", {31'd0, yv0}, 0);
        chk("fl_level", {29'd0, lv0}, 0);
        repeat (10) @(posedge clk);
        #1;

        // Asynchronous reset pulse mid-DRIVE.
        push0(3'd6);
        push0(3'd2);
        chk("ar_driving", {24'd0, y0}, 32'h40);
        #1;
        rst_n = 1'b0;
        ab_req0++;
        q0.delete();
        #1;
        chk("ar_y", {24'd0, y0}, 0);
        chk("ar_valid", {31'd0, yv0}, 0);
        chk("ar_level", {29'd0, lv0}, 0);
        chk("ar_in_ready", {31'd0, ir0}, 0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_ready_after", {31'd0, ir0}, 1);
        push0(3'd1);
        @(posedge clk);
        #1;
        chk("ar_c1_y", {24'd0, y0}, 32'h02);
        chk("ar_c1_valid", {31'd0, yv0}, 1);
        wait_idle0(50);

        // u1: HOLD=2, GAP=0 back-to-back words 3 then 6.
        iv1 = 1'b1;
        ic1 = 3'd3;
        @(negedge clk);
        chk("b2b_ready_a", {31'd0, ir1}, 1);
        @(posedge clk);
        q1.push_back(8'h08);
        #1;
        ic1 = 3'd6;
        @(negedge clk);
        chk("b2b_ready_b", {31'd0, ir1}, 1);
        @(posedge clk);
        q1.push_back(8'h40);
        #1;
        iv1 = 1'b0;
        chk("b2b_c1", {24'd0, y1}, 32'h08);
        @(posedge clk);
        #1;
        chk("b2b_c2", {24'd0, y1}, 32'h08);
        @(posedge clk);
        #1;
        chk("b2b_c3", {24'd0, y1}, 32'h40);
        chk("b2b_c3_valid", {31'd0, yv1}, 1);
        @(posedge clk);
        #1;
        chk("b2b_c4", {24'd0, y1}, 32'h40);
        @(posedge clk);
        #1;
        chk("b2b_end_y", {24'd0, y1}, 0);
        chk("b2b_end_valid", {31'd0, yv1}, 0);
        chk("b2b_end_level", {29'd0, lv1}, 0);

        repeat (5) @(posedge clk);
        #1;
        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
